// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file for the T-proc pipeline. It has two combinational read
//   ports, one synchronous write port, and register 0 hardwired to zero.
//   It also provides write-to-read bypass, a per-register busy scoreboard,
//   a window of tap outputs, and a sequential bulk-clear sweep.
//
// Ports
//   clock, ctrl_reset_n              rising-edge clock, async active-low reset
//   ctrl_writeEnable/WriteReg/data   write strobe, address, data
//   ctrl_readRegA/B -> data_readRegA/B  combinational read ports
//   ctrl_busySet, ctrl_busyReg       mark a register as having a pending write
//   busyA, busyB                     pending-write flags for the read addresses
//   ctrl_clearStart -> clear_busy    start pulse / in-progress flag of the sweep
//   reg_taps                         stored regs TAP_BASE.., lowest index in LSBs
//
// FSM
//   state | meaning
//   IDLE  | normal operation: writes, busy sets and bypass are active
//   SWEEP | clears reg[sweepAddr] each cycle; external updates are dropped
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int TAP_BASE   = 25,
    parameter int TAP_COUNT  = 5,
    parameter int BYPASS     = 1
) (
    input  logic                            clock,
    input  logic                            ctrl_reset_n,
    input  logic                            ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0]           ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]           data_writeReg,
    input  logic [ADDR_WIDTH-1:0]           ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0]           ctrl_readRegB,
    output logic [DATA_WIDTH-1:0]           data_readRegA,
    output logic [DATA_WIDTH-1:0]           data_readRegB,
    input  logic                            ctrl_busySet,
    input  logic [ADDR_WIDTH-1:0]           ctrl_busyReg,
    output logic                            busyA,
    output logic                            busyB,
    input  logic                            ctrl_clearStart,
    output logic                            clear_busy,
    output logic [TAP_COUNT*DATA_WIDTH-1:0] reg_taps
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } stateType;

    stateType              state, nextState;
    logic [ADDR_WIDTH-1:0] sweepAddr, nextSweepAddr;

    logic [DATA_WIDTH-1:0] regFile [DEPTH];
    logic [DEPTH-1:0]      busyBits;

    logic isIdle, writeHit, busyHit;

    assign isIdle   = (state == IDLE);
    assign writeHit = isIdle && ctrl_writeEnable && (ctrl_writeReg != '0);
    assign busyHit  = isIdle && ctrl_busySet && (ctrl_busyReg != '0);

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state     <= IDLE;
            sweepAddr <= '0;
        end else begin
            state     <= nextState;
            sweepAddr <= nextSweepAddr;
        end
    end

    always_comb begin
        nextState     = state;
        nextSweepAddr = sweepAddr;
        case (state)
            IDLE: begin
                if (ctrl_clearStart) begin
                    nextState     = SWEEP;
                    // Register 0 is already constant zero, so start at 1.
                    nextSweepAddr = ADDR_WIDTH'(1);
                end
            end
            SWEEP: begin
                if (sweepAddr == LAST_ADDR) begin
                    nextState     = IDLE;
                    nextSweepAddr = '0;
                end else begin
                    nextSweepAddr = sweepAddr + ADDR_WIDTH'(1);
                end
            end
            default: begin
                nextState     = IDLE;
                nextSweepAddr = '0;
            end
        endcase
    end

    // Entry 0 and busyBits[0] are only ever written by reset, so they stay zero.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regFile[i] <= '0;
            end
            busyBits <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (state == SWEEP) begin
                    if (sweepAddr == ADDR_WIDTH'(i)) begin
                        regFile[i]  <= '0;
                        busyBits[i] <= 1'b0;
                    end
                end else begin
                    if (writeHit && (ctrl_writeReg == ADDR_WIDTH'(i))) begin
                        regFile[i]  <= data_writeReg;
                        busyBits[i] <= 1'b0;
                    end
                    // A busy set is applied last, so it wins over a same-cycle write.
                    if (busyHit && (ctrl_busyReg == ADDR_WIDTH'(i))) begin
                        busyBits[i] <= 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] readPort(input logic [ADDR_WIDTH-1:0] addr);
        if (addr == '0) begin
            return '0;
        end
        if ((BYPASS != 0) && writeHit && (ctrl_writeReg == addr)) begin
            return data_writeReg;
        end
        return regFile[addr];
    endfunction

    // A write landing this cycle retires the pending flag early, unless a new
    // busy set on the same register re-arms it.
    function automatic logic busyPort(input logic [ADDR_WIDTH-1:0] addr);
        logic retiring;
        retiring = (BYPASS != 0) && writeHit && (ctrl_writeReg == addr)
                   && !(busyHit && (ctrl_busyReg == addr));
        return busyBits[addr] && !retiring;
    endfunction

    always_comb begin
        data_readRegA = readPort(ctrl_readRegA);
        data_readRegB = readPort(ctrl_readRegB);
        busyA         = busyPort(ctrl_readRegA);
        busyB         = busyPort(ctrl_readRegB);
    end

    assign clear_busy = (state == SWEEP);

    for (genvar k = 0; k < TAP_COUNT; k++) begin : gTap
        assign reg_taps[k*DATA_WIDTH +: DATA_WIDTH] = regFile[TAP_BASE + k];
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int TBASE = 25;
    localparam int TCNT  = 5;

    logic                 clock = 1'b0;
    logic                 ctrl_reset_n;
    logic                 ctrl_writeEnable;
    logic [AW-1:0]        ctrl_writeReg;
    logic [DW-1:0]        data_writeReg;
    logic [AW-1:0]        ctrl_readRegA;
    logic [AW-1:0]        ctrl_readRegB;
    logic [DW-1:0]        data_readRegA;
    logic [DW-1:0]        data_readRegB;
    logic                 ctrl_busySet;
    logic [AW-1:0]        ctrl_busyReg;
    logic                 busyA;
    logic                 busyB;
    logic                 ctrl_clearStart;
    logic                 clear_busy;
    logic [TCNT*DW-1:0]   reg_taps;

    regfile_scoreboard #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAP_BASE(TBASE), .TAP_COUNT(TCNT), .BYPASS(1)
    ) dut (
        .clock(clock),
        .ctrl_reset_n(ctrl_reset_n),
        .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA),
        .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(data_readRegA),
        .data_readRegB(data_readRegB),
        .ctrl_busySet(ctrl_busySet),
        .ctrl_busyReg(ctrl_busyReg),
        .busyA(busyA),
        .busyB(busyB),
        .ctrl_clearStart(ctrl_clearStart),
        .clear_busy(clear_busy),
        .reg_taps(reg_taps)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays plus a count of sweep cycles still to run.
    logic [DW-1:0] mReg  [DEPTH];
    logic          mBusy [DEPTH];
    int            sweepLeft;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] expRead(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (sweepLeft == 0 && ctrl_writeEnable && ctrl_writeReg == a) return data_writeReg;
        return mReg[a];
    endfunction

    function automatic logic expBusy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (sweepLeft == 0 && ctrl_writeEnable && ctrl_writeReg == a
            && !(ctrl_busySet && ctrl_busyReg == a)) return 1'b0;
        return mBusy[a];
    endfunction

    function automatic logic [TCNT*DW-1:0] expTaps();
        logic [TCNT*DW-1:0] t;
        for (int k = 0; k < TCNT; k++) t[k*DW +: DW] = mReg[TBASE + k];
        return t;
    endfunction

    task automatic checkAll();
        check("readA", 160'(data_readRegA), 160'(expRead(ctrl_readRegA)));
        check("readB", 160'(data_readRegB), 160'(expRead(ctrl_readRegB)));
        check("busyA", 160'(busyA), 160'(expBusy(ctrl_readRegA)));
        check("busyB", 160'(busyB), 160'(expBusy(ctrl_readRegB)));
        check("clearBusy", 160'(clear_busy), 160'(sweepLeft != 0));
        check("taps", 160'(reg_taps), 160'(expTaps()));
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) begin
            mReg[i]  = '0;
            mBusy[i] = 1'b0;
        end
        sweepLeft = 0;
    endtask

    task automatic modelEdge();
        if (sweepLeft != 0) begin
            // Registers are cleared in ascending order 1..DEPTH-1.
            mReg[DEPTH - sweepLeft]  = '0;
            mBusy[DEPTH - sweepLeft] = 1'b0;
            sweepLeft--;
        end else begin
            if (ctrl_writeEnable && ctrl_writeReg != 0) begin
                mReg[ctrl_writeReg]  = data_writeReg;
                mBusy[ctrl_writeReg] = 1'b0;
            end
            if (ctrl_busySet && ctrl_busyReg != 0) mBusy[ctrl_busyReg] = 1'b1;
            if (ctrl_clearStart) sweepLeft = DEPTH - 1;
        end
    endtask

    task automatic sampleAndCheck();
        @(negedge clock);
        checkAll();
    endtask

    task automatic finishCycle();
        @(posedge clock);
        modelEdge();
        #1;
    endtask

    task automatic tick();
        sampleAndCheck();
        finishCycle();
    endtask

    task automatic idleInputs();
        ctrl_writeEnable = 1'b0;
        ctrl_busySet     = 1'b0;
        ctrl_clearStart  = 1'b0;
    endtask

    task automatic writeReg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = a;
        data_writeReg    = d;
        tick();
        ctrl_writeEnable = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sweepCycles;
        ctrl_reset_n  = 1'b0;
        idleInputs();
        ctrl_writeReg = '0;
        data_writeReg = '0;
        ctrl_readRegA = 5'd3;
        ctrl_readRegB = 5'd0;
        ctrl_busyReg  = '0;
        modelReset();

        // Reset state
        #2;
        checkAll();
        check("resetReadA", 160'(data_readRegA), 160'(0));
        @(posedge clock);
        #1;
        ctrl_reset_n = 1'b1;

        // Basic write/read, register 0
        writeReg(5'd5, 32'hDEADBEEF);
        ctrl_readRegA = 5'd5;
        ctrl_readRegB = 5'd0;
        sampleAndCheck();
        check("r5ReadA", 160'(data_readRegA), 160'(32'hDEADBEEF));
        check("r0ReadB", 160'(data_readRegB), 160'(0));
        finishCycle();
        writeReg(5'd0, 32'h1234);
        ctrl_readRegA = 5'd0;
        sampleAndCheck();
        check("r0AfterWrite", 160'(data_readRegA), 160'(0));
        finishCycle();

        // Bypass
        writeReg(5'd7, 32'h11);
        ctrl_readRegA    = 5'd7;
        ctrl_readRegB    = 5'd7;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd7;
        data_writeReg    = 32'h22;
        sampleAndCheck();
        check("bypassA", 160'(data_readRegA), 160'(32'h22));
        finishCycle();
        idleInputs();
        sampleAndCheck();
        check("afterBypassA", 160'(data_readRegA), 160'(32'h22));
        check("afterBypassB", 160'(data_readRegB), 160'(32'h22));
        finishCycle();

        // Scoreboard
        ctrl_busySet  = 1'b1;
        ctrl_busyReg  = 5'd9;
        ctrl_readRegA = 5'd9;
        tick();
        ctrl_busySet = 1'b0;
        sampleAndCheck();
        check("busySet9", 160'(busyA), 160'(1));
        finishCycle();
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd9;
        data_writeReg    = 32'h5;
        sampleAndCheck();
        check("busyRetireComb", 160'(busyA), 160'(0));
        finishCycle();
        idleInputs();
        sampleAndCheck();
        check("busyRetired", 160'(busyA), 160'(0));
        finishCycle();
        ctrl_writeEnable = 1'b1;
        ctrl_busySet     = 1'b1;
        ctrl_busyReg     = 5'd9;
        data_writeReg    = 32'h6;
        tick();
        idleInputs();
        sampleAndCheck();
        check("setWinsOverWrite", 160'(busyA), 160'(1));
        finishCycle();

        // Taps
        for (int i = 25; i < 30; i++) writeReg(AW'(i), DW'(i));
        sampleAndCheck();
        check("tapsFill", 160'(reg_taps), {32'd29, 32'd28, 32'd27, 32'd26, 32'd25});
        finishCycle();
        ctrl_readRegA    = 5'd26;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd26;
        data_writeReg    = 32'hAA;
        sampleAndCheck();
        check("tapBypassRead", 160'(data_readRegA), 160'(32'hAA));
        check("tapNotBypassed", 160'(reg_taps), {32'd29, 32'd28, 32'd27, 32'd26, 32'd25});
        finishCycle();
        idleInputs();
        sampleAndCheck();
        check("tapUpdated", 160'(reg_taps), {32'd29, 32'd28, 32'd27, 32'hAA, 32'd25});
        finishCycle();

        // Randomised traffic; addresses drawn from a narrow range for frequent hits
        for (int n = 0; n < 400; n++) begin
            ctrl_writeEnable = ($urandom_range(0, 1) == 1);
            ctrl_writeReg    = AW'($urandom_range(0, 7));
            data_writeReg    = $urandom;
            ctrl_busySet     = ($urandom_range(0, 3) == 0);
            ctrl_busyReg     = AW'($urandom_range(0, 7));
            ctrl_readRegA    = AW'($urandom_range(0, 7));
            ctrl_readRegB    = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31))
                                                           : AW'($urandom_range(0, 7));
            ctrl_clearStart  = ($urandom_range(0, 99) == 0);
            tick();
        end
        idleInputs();
        while (sweepLeft != 0) tick();

        // Full sweep
        for (int i = 1; i < DEPTH; i++) writeReg(AW'(i), $urandom | 32'h1);
        ctrl_busySet = 1'b1;
        ctrl_busyReg = 5'd3;
        tick();
        idleInputs();
        ctrl_clearStart = 1'b1;
        tick();
        ctrl_clearStart = 1'b0;
        sweepCycles = 0;
        for (int n = 0; n < 100; n++) begin
            ctrl_readRegA = AW'($urandom_range(0, 31));
            ctrl_readRegB = 5'd3;
            ctrl_writeEnable = (sweepCycles == 5);
            ctrl_writeReg    = 5'd4;
            data_writeReg    = 32'hBEEF;
            sampleAndCheck();
            if (!clear_busy) begin
                finishCycle();
                break;
            end
            sweepCycles++;
            finishCycle();
        end
        idleInputs();
        check("sweepLength", 160'(sweepCycles), 160'(31));
        for (int i = 0; i < DEPTH; i++) begin
            ctrl_readRegA = AW'(i);
            ctrl_readRegB = AW'(DEPTH - 1 - i);
            sampleAndCheck();
            if (i == 4) check("droppedWriteR4", 160'(data_readRegA), 160'(0));
            if (i == 3) check("busy3Cleared", 160'(busyA), 160'(0));
            finishCycle();
        end

        // Reset in the middle of a sweep
        writeReg(5'd2, 32'h7);
        writeReg(5'd20, 32'h99);
        ctrl_clearStart = 1'b1;
        tick();
        ctrl_clearStart = 1'b0;
        ctrl_readRegA   = 5'd20;
        ctrl_readRegB   = 5'd2;
        for (int n = 0; n < 10; n++) tick();
        ctrl_reset_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        check("midSweepClear", 160'(clear_busy), 160'(0));
        check("midSweepR20", 160'(data_readRegA), 160'(0));
        @(posedge clock);
        #1;
        ctrl_reset_n = 1'b1;
        tick();
        check("noResume", 160'(clear_busy), 160'(0));
        writeReg(5'd2, 32'hA);
        ctrl_readRegA = 5'd2;
        sampleAndCheck();
        check("postResetR2", 160'(data_readRegA), 160'(32'hA));
        finishCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
